address_sequencer: RTL and testbench

Controller that sequences the CPU's address register and arbitrates it between instruction fetch and data (single or multi-word) accesses. It drives the register's source select and update strobe, issues the memory request/write-enable, and handles the memory ready handshake. It sits between the core control logic (fetch/data requesters) and the address register + memory interface. Multi-word transfers advance through the address incrementer without re-entering the ALU bus.

---
 rtl/addr_seq_pkg.sv | 16 +
 rtl/address_sequencer.sv | 115 +++++++++++
 tb/tb_address_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/addr_seq_pkg.sv
// Shared types for the address sequencer.
//   state_t       : controller state (IDLE, FETCH, DATA)
//   ADDR_SEL_*    : address register source select encodings
package addr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    DATA  = 2'b10
  } state_t;

  localparam logic [1:0] ADDR_SEL_ALU = 2'b00;
  localparam logic [1:0] ADDR_SEL_PC  = 2'b01;
  localparam logic [1:0] ADDR_SEL_INC = 2'b10;

endpackage

// File: rtl/address_sequencer.sv
// Address register sequencer and memory access arbiter.
// Arbitrates the CPU address register between instruction fetch and
// (multi-word) data accesses, drives its source select / load strobe, and
// runs the memory request / ready handshake.
//   clk, rst_n                 : clock, synchronous active-low reset
//   fetch_req, pc_load         : fetch request, take address from PC bus
//   data_req, data_we          : data request, store(1)/load(0)
//   data_count                 : words in data access (0 means 1)
//   mem_ready                  : memory completes current word
//   addr_select, addr_update   : address register source and load strobe
//   mem_req, mem_we            : memory access active, write enable
//   fetch_done, data_done      : completion pulses
//   busy                       : a transaction is in progress
module address_sequencer
  import addr_seq_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_req,
  input  logic             pc_load,
  input  logic             data_req,
  input  logic             data_we,
  input  logic [CNT_W-1:0] data_count,
  input  logic             mem_ready,
  output logic [1:0]       addr_select,
  output logic             addr_update,
  output logic             mem_req,
  output logic             mem_we,
  output logic             fetch_done,
  output logic             data_done,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             we_q, we_d;
  logic             seq_valid_q, seq_valid_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      we_q        <= 1'b0;
      seq_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      we_q        <= we_d;
      seq_valid_q <= seq_valid_d;
    end
  end

  // Outputs are forced to their idle values while reset is asserted so a
  // requester holding its request through reset sees no spurious strobe.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    we_d        = we_q;
    seq_valid_d = seq_valid_q;
    addr_select = ADDR_SEL_INC;
    addr_update = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    fetch_done  = 1'b0;
    data_done   = 1'b0;
    busy        = 1'b0;

    if (rst_n) begin
      busy = (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          if (data_req) begin
            addr_update = 1'b1;
            addr_select = ADDR_SEL_ALU;
            remaining_d = (data_count == '0) ? CNT_W'(1) : data_count;
            we_d        = data_we;
            state_d     = DATA;
          end else if (fetch_req) begin
            addr_update = 1'b1;
            // Sequential fetch reuses the incremented last fetch address.
            addr_select = (seq_valid_q && !pc_load) ? ADDR_SEL_INC : ADDR_SEL_PC;
            state_d     = FETCH;
          end
        end
        FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            fetch_done  = 1'b1;
            seq_valid_d = 1'b1;
            state_d     = IDLE;
          end
        end
        DATA: begin
          mem_req = 1'b1;
          mem_we  = we_q;
          if (mem_ready) begin
            if (remaining_q == CNT_W'(1)) begin
              data_done   = 1'b1;
              // Address register no longer follows the fetch stream.
              seq_valid_d = 1'b0;
              state_d     = IDLE;
            end else begin
              remaining_d = remaining_q - CNT_W'(1);
              addr_update = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_address_sequencer.sv
module tb_address_sequencer;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [1:0] sel;
    logic       upd;
    logic       req;
    logic       we;
    logic       fd;
    logic       dd;
    logic       busy;
  } outs_t;

  typedef struct {
    logic       rst_n, f, pc, d, we;
    logic [3:0] cnt;
    logic       rdy;
    outs_t      exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, fetch_req, pc_load, data_req, data_we, mem_ready;
  logic [CNT_W-1:0] data_count;
  logic [1:0]       addr_select;
  logic             addr_update, mem_req, mem_we, fetch_done, data_done, busy;

  address_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc_load(pc_load),
    .data_req(data_req), .data_we(data_we), .data_count(data_count),
    .mem_ready(mem_ready), .addr_select(addr_select), .addr_update(addr_update),
    .mem_req(mem_req), .mem_we(mem_we), .fetch_done(fetch_done),
    .data_done(data_done), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  outs_t last_o;
  vec_t  vecs[$];

  // Transaction-level reference: what is outstanding, how many words are
  // still owed, and whether the address register continues the fetch stream.
  int m_kind  = 0;   // 0 none, 1 fetch, 2 data
  int m_words = 0;
  bit m_store = 0;
  bit m_seq   = 0;

  task automatic model_eval(output outs_t e, output int kind_n, output int words_n,
                            output bit store_n, output bit seq_n);
    e = '{sel: 2'b10, default: 1'b0};
    kind_n = m_kind; words_n = m_words; store_n = m_store; seq_n = m_seq;
    if (!rst_n) begin
      kind_n = 0; words_n = 0; store_n = 0; seq_n = 0;
    end else if (m_kind == 0) begin
      if (data_req) begin
        e.upd = 1; e.sel = 2'b00;
        kind_n = 2; words_n = (data_count == 0) ? 1 : int'(data_count); store_n = data_we;
      end else if (fetch_req) begin
        e.upd = 1; e.sel = (m_seq && !pc_load) ? 2'b10 : 2'b01;
        kind_n = 1;
      end
    end else begin
      e.req = 1; e.busy = 1;
      e.we = (m_kind == 2) ? m_store : 1'b0;
      if (mem_ready) begin
        if (m_kind == 1) begin
          e.fd = 1; kind_n = 0; seq_n = 1;
        end else begin
          words_n = m_words - 1;
          if (words_n == 0) begin
            e.dd = 1; kind_n = 0; seq_n = 0;
          end else begin
            e.upd = 1;
          end
        end
      end
    end
  endtask

  task automatic check(input string name, input outs_t act, input outs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got sel=%b upd=%b req=%b we=%b fd=%b dd=%b busy=%b, want sel=%b upd=%b req=%b we=%b fd=%b dd=%b busy=%b",
               name, act.sel, act.upd, act.req, act.we, act.fd, act.dd, act.busy,
               exp.sel, exp.upd, exp.req, exp.we, exp.fd, exp.dd, exp.busy);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // One clock: sample outputs mid-cycle, optionally compare, then advance.
  task automatic tick(input string name, input bit chk_model, input bit chk_tbl,
                      input outs_t tbl_exp);
    outs_t e;
    int kn, wn;
    bit sn, qn;
    @(negedge clk);
    model_eval(e, kn, wn, sn, qn);
    last_o = {addr_select, addr_update, mem_req, mem_we, fetch_done, data_done, busy};
    if (chk_model) check(name, last_o, e);
    if (chk_tbl)   check(name, last_o, tbl_exp);
    @(posedge clk);
    m_kind = kn; m_words = wn; m_store = sn; m_seq = qn;
    #1;
  endtask

  task automatic drive(input logic r, input logic f, input logic pc, input logic d,
                       input logic we, input logic [3:0] cnt, input logic rdy);
    rst_n = r; fetch_req = f; pc_load = pc; data_req = d; data_we = we;
    data_count = cnt; mem_ready = rdy;
  endtask

  task automatic add(input logic r, input logic f, input logic pc, input logic d,
                     input logic we, input logic [3:0] cnt, input logic rdy,
                     input logic [1:0] sel, input logic upd, input logic req,
                     input logic mwe, input logic fd, input logic dd, input logic bsy);
    vec_t v;
    v.rst_n = r; v.f = f; v.pc = pc; v.d = d; v.we = we; v.cnt = cnt; v.rdy = rdy;
    v.exp = {sel, upd, req, mwe, fd, dd, bsy};
    vecs.push_back(v);
  endtask

  initial begin
    int dd_cycle, we_cnt;
    drive(0, 1, 0, 1, 0, 0, 0);

    //   rst f pc d we cnt rdy | sel  upd req we fd dd busy
    add(0, 1, 0, 1, 0, 0, 0,   2'b10, 0, 0, 0, 0, 0, 0);  // reset, requests high
    add(0, 1, 0, 1, 0, 0, 0,   2'b10, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 1,   2'b01, 1, 0, 0, 0, 0, 0);  // first fetch from PC
    add(1, 0, 0, 0, 0, 0, 1,   2'b10, 0, 1, 0, 1, 0, 1);
    add(1, 1, 0, 0, 0, 0, 1,   2'b10, 1, 0, 0, 0, 0, 0);  // sequential fetch
    add(1, 0, 0, 0, 0, 0, 1,   2'b10, 0, 1, 0, 1, 0, 1);
    add(1, 0, 0, 0, 0, 0, 1,   2'b10, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 3, 0,   2'b00, 1, 0, 0, 0, 0, 0);  // burst store of 3
    add(1, 0, 0, 0, 0, 0, 1,   2'b10, 1, 1, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0,   2'b10, 0, 1, 1, 0, 0, 1);  // wait on word 2
    add(1, 0, 0, 0, 0, 0, 1,   2'b10, 1, 1, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 1,   2'b10, 0, 1, 1, 0, 1, 1);
    add(1, 1, 0, 0, 0, 0, 1,   2'b01, 1, 0, 0, 0, 0, 0);  // fetch after data: PC
    add(1, 0, 0, 0, 0, 0, 1,   2'b10, 0, 1, 0, 1, 0, 1);
    add(1, 1, 0, 1, 0, 0, 1,   2'b00, 1, 0, 0, 0, 0, 0);  // both: data wins, count 0
    add(1, 1, 0, 0, 0, 0, 1,   2'b10, 0, 1, 0, 0, 1, 1);
    add(1, 1, 0, 0, 0, 0, 0,   2'b01, 1, 0, 0, 0, 0, 0);  // pending fetch served
    add(1, 0, 0, 1, 1, 7, 0,   2'b10, 0, 1, 0, 0, 0, 1);  // data_req ignored mid-fetch
    add(1, 0, 0, 1, 1, 7, 1,   2'b10, 0, 1, 0, 1, 0, 1);
    add(1, 1, 1, 0, 0, 0, 1,   2'b01, 1, 0, 0, 0, 0, 0);  // branch with seq_valid=1
    add(1, 0, 0, 0, 0, 0, 1,   2'b10, 0, 1, 0, 1, 0, 1);
    add(1, 1, 0, 1, 0, 5, 1,   2'b00, 1, 0, 0, 0, 0, 0);  // load burst of 5
    add(1, 0, 0, 0, 0, 0, 1,   2'b10, 1, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 1,   2'b10, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1,   2'b10, 0, 0, 0, 0, 0, 0);  // reset mid-burst
    add(1, 0, 0, 0, 0, 0, 1,   2'b10, 0, 0, 0, 0, 0, 0);  // no data_done
    add(1, 1, 0, 0, 0, 0, 1,   2'b01, 1, 0, 0, 0, 0, 0);  // seq_valid cleared
    add(1, 0, 0, 0, 0, 0, 1,   2'b10, 0, 1, 0, 1, 0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].f, vecs[i].pc, vecs[i].d, vecs[i].we,
            vecs[i].cnt, vecs[i].rdy);
      tick($sformatf("vec%0d", i), 1'b0, 1'b1, vecs[i].exp);
    end

    // Maximum burst, zero wait: data_done on the 15th cycle after accept.
    drive(0, 0, 0, 0, 0, 0, 0);
    tick("burst_rst", 1'b1, 1'b0, '0);
    drive(1, 0, 0, 1, 1, 4'd15, 1);
    tick("burst_accept", 1'b1, 1'b0, '0);
    drive(1, 0, 0, 0, 0, 0, 1);
    dd_cycle = 0;
    we_cnt   = 0;
    for (int k = 1; k <= 40; k++) begin
      tick($sformatf("burst_c%0d", k), 1'b1, 1'b0, '0);
      if (last_o.we) we_cnt++;
      if (last_o.dd) begin
        dd_cycle = k;
        break;
      end
    end
    check_int("burst_done_cycle", dd_cycle, 15);
    check_int("burst_we_cycles", we_cnt, 15);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 2) != 0));
      tick($sformatf("rand%0d", i), 1'b1, 1'b0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
